mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles waiting for mem_ready per access (legal 1..255).
REQ-002 SHALL have port CLK  input  1  clock, all state on rising edge.
REQ-003 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_en  input  1  memory-stage access request.
REQ-005 SHALL have port req_rw  input  1  1=write, 0=read.
REQ-006 SHALL have port req_size  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, LSB-justified.
REQ-009 SHALL have ports mem_en/mem_rw/mem_size/mem_addr/mem_wdata  output  1/1/2/32/32  registered memory command.
REQ-010 SHALL have port mem_ready  input  1  memory completion strobe.
REQ-011 SHALL have port mem_rdata  input  32  memory read word.
REQ-012 SHALL have port stall  output  1  hold upstream pipeline registers.
REQ-013 SHALL have ports rdata_out/rdata_valid  output  32/1  aligned, zero-extended load result and its one-cycle strobe.
REQ-014 SHALL have port err  output  1  one-cycle pulse on timeout or trapped misalignment.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE with req_en=1 SHALL assert stall combinationally that cycle, latch the request into mem_* and enter BUSY next edge with mem_en=1.
REQ-017 IDLE with req_en=0 SHALL keep stall=0, mem_en=0.
REQ-018 BUSY SHALL hold stall=1 and mem_* stable until the edge on which mem_ready=1 is sampled.
REQ-019 BUSY with mem_ready=1 SHALL drop mem_en, capture load data (read only) and enter DONE; minimum access latency is 2 cycles from req_en to DONE.
REQ-020 DONE SHALL last exactly one cycle: stall=0, rdata_valid=1 for reads, ignore req_en, then go to IDLE.
REQ-021 Load alignment SHALL pick byte lane addr[1:0] or halfword lane addr[1] from mem_rdata and zero-extend to 32 bits; word passes unchanged.
REQ-022 Store data SHALL be replicated into the addressed lane(s) of mem_wdata.
REQ-023 BUSY SHALL count cycles in an 8-bit counter cleared on BUSY entry; when the count reaches TIMEOUT without mem_ready, SHALL drop mem_en, pulse err, force rdata_out=0 and enter DONE.
REQ-024 mem_ready asserted in the same cycle as timeout SHALL be treated as success (no err).
REQ-025 mem_ready outside BUSY SHALL be ignored.
REQ-026 req_size=11 SHALL always be treated as a misaligned access.

Reset
REQ-027 CLR=1 SHALL immediately force state IDLE, counter 0, and all outputs 0 (stall, mem_en, err, rdata_valid, rdata_out, mem_* buses).
REQ-028 CLR during BUSY SHALL abort the access without err; no resumption after release.

Configuration
REQ-029 With MEM_MISALIGN_TRAP_EN defined, a misaligned request in IDLE SHALL issue no memory command, pulse err, and go directly to DONE (stall high one cycle only).
REQ-030 Without MEM_MISALIGN_TRAP_EN, misaligned addresses SHALL be aligned down (halfword: addr[0]=0, word/illegal: addr[1:0]=0, illegal treated as word) and the access proceeds normally with err=0.

Structure
REQ-031 Package mem_ctrl_pkg SHALL hold size encodings, FSM state enum, and default TIMEOUT constant.
REQ-032 Lane extract/replicate SHALL live in combinational sub-module mem_lane_align.

Verification
REQ-033 Read word addr 0x100, mem_ready on 3rd BUSY cycle, mem_rdata 0xDEADBEEF -> stall high 4 cycles, rdata_out=0xDEADBEEF, rdata_valid one cycle.
REQ-034 Read byte addr 0x103, mem_rdata 0xAABBCCDD -> rdata_out=0x000000AA.
REQ-035 Write half addr 0x202, wdata 0x1234, no mem_ready for TIMEOUT=16 cycles -> err pulse, mem_en low, DONE then IDLE.
REQ-036 Word read addr 0x101: with MEM_MISALIGN_TRAP_EN -> err, mem_en never high; without -> mem_addr=0x100, err=0.
REQ-037 CLR asserted mid-BUSY -> mem_en and stall 0 same cycle, state IDLE, no err.
REQ-038 Back-to-back requests (req_en held, new address after DONE) -> no re-issue in DONE, second access starts from IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory-stage controller.
// Contents: access-size encodings, controller FSM state enum, default timeout,
//           and helpers for misalignment detection and address alignment.
package mem_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The illegal size counts as misaligned whatever the address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Rounds the address down to the natural boundary of the access size;
    // the illegal size is rounded like a word.
    function automatic logic [31:0] align_down(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] a;
        case (size)
            SZ_BYTE: a = addr;
            SZ_HALF: a = {addr[31:1], 1'b0};
            default: a = {addr[31:2], 2'b00};
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational lane handling for loads and stores.
// Ports: ld_size_i/ld_addr_lo_i/rdata_i -> rdata_o (lane picked, zero-extended);
//        st_size_i/wdata_i -> wdata_o (store data replicated across all lanes of its size).
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wdata_o
);

    always_comb begin
        rdata_o = rdata_i;
        case (ld_size_i)
            SZ_BYTE: rdata_o = {24'b0, rdata_i[{ld_addr_lo_i, 3'b000} +: 8]};
            SZ_HALF: rdata_o = ld_addr_lo_i[1] ? {16'b0, rdata_i[31:16]} : {16'b0, rdata_i[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

    // Replicating into every lane puts the data in the addressed lane(s)
    // without needing the address here; the memory picks lanes from addr/size.
    always_comb begin
        wdata_o = wdata_i;
        case (st_size_i)
            SZ_BYTE: wdata_o = {4{wdata_i[7:0]}};
            SZ_HALF: wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage access controller (IDLE -> BUSY -> DONE) with timeout.
// Ports: CLK/CLR (async active-high reset); req_* request in; mem_* registered command out,
//        mem_ready/mem_rdata back; stall, rdata_out/rdata_valid, err pulse.
// Option: define MEM_MISALIGN_TRAP_EN to trap misaligned requests instead of aligning them down.
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        req_en,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        err
);

    // Last BUSY count value before giving up: TIMEOUT BUSY cycles in total.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        mem_en_q, mem_rw_q;
    logic [1:0]  mem_size_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [31:0] rdata_out_q;
    logic        rdata_valid_q, err_q;

    logic        stall_c, issue, trap_hit, complete, timeout;
    logic        trap_req;
    logic [1:0]  size_eff;
    logic [31:0] addr_aligned;
    logic [31:0] rdata_aligned, wdata_repl;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_req = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap_req = 1'b0;
`endif

    assign size_eff     = (req_size == SZ_ILL) ? SZ_WORD : req_size;
    assign addr_aligned = align_down(req_size, req_addr);

    // Loads are aligned from the latched command, stores from the live request.
    mem_lane_align u_lane (
        .ld_size_i    (mem_size_q),
        .ld_addr_lo_i (mem_addr_q[1:0]),
        .rdata_i      (mem_rdata),
        .rdata_o      (rdata_aligned),
        .st_size_i    (size_eff),
        .wdata_i      (req_wdata),
        .wdata_o      (wdata_repl)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_en) state_d = trap_req ? ST_DONE : ST_BUSY;
            ST_BUSY: if (mem_ready || (cnt_q == CNT_LAST)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_c  = 1'b0;
        issue    = 1'b0;
        trap_hit = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        // Counter is zero everywhere except BUSY, so it starts cleared on entry.
        cnt_d    = 8'd0;
        case (state_q)
            ST_IDLE: begin
                stall_c  = req_en;
                issue    = req_en & ~trap_req;
                trap_hit = req_en & trap_req;
            end
            ST_BUSY: begin
                stall_c  = 1'b1;
                complete = mem_ready;
                // A ready arriving on the last allowed cycle still wins.
                timeout  = ~mem_ready & (cnt_q == CNT_LAST);
                cnt_d    = cnt_q + 8'd1;
            end
            default: ;
        endcase
    end

    // Stall is combinational, so reset has to mask it directly.
    assign stall = stall_c & ~CLR;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            mem_en_q      <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_size_q    <= 2'b00;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            rdata_out_q   <= 32'h0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            err_q         <= timeout | trap_hit;
            rdata_valid_q <= ((complete | timeout) & ~mem_rw_q) | (trap_hit & ~req_rw);

            if (issue) begin
                mem_en_q    <= 1'b1;
                mem_rw_q    <= req_rw;
                mem_size_q  <= size_eff;
                mem_addr_q  <= addr_aligned;
                mem_wdata_q <= wdata_repl;
            end else if (complete | timeout) begin
                mem_en_q    <= 1'b0;
            end

            if (complete & ~mem_rw_q) begin
                rdata_out_q <= rdata_aligned;
            end else if (timeout | trap_hit) begin
                rdata_out_q <= 32'h0;
            end
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_rw      = mem_rw_q;
    assign mem_size    = mem_size_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata_out   = rdata_out_q;
    assign rdata_valid = rdata_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed bench for mem_stage_ctrl with TIMEOUT=16.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Expectations for misaligned accesses follow MEM_MISALIGN_TRAP_EN when it is defined.
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        req_en, req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_en, mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] rdata_out;
    logic        rdata_valid, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations collected by the access task.
    int          o_stall, o_en, o_err, o_vld;
    logic [31:0] o_addr, o_wd, o_rdata;
    logic [1:0]  o_size;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(.TIMEOUT(16)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .req_en      (req_en),
        .req_rw      (req_rw),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem_en      (mem_en),
        .mem_rw      (mem_rw),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request presented for a single cycle, then 21 more cycles observed.
    // Cycle 0 is the IDLE request cycle; mem_ready is driven on cycle rdy_at only.
    task automatic access(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdy_at, input logic [31:0] rd);
        o_stall = 0; o_en = 0; o_err = 0; o_vld = 0;
        o_addr = '0; o_wd = '0; o_rdata = '0; o_size = '0;
        req_rw = rw; req_size = sz; req_addr = addr; req_wdata = wd; req_en = 1'b1;
        for (int c = 0; c < 22; c++) begin
            mem_ready = (c == rdy_at);
            if (c == rdy_at) mem_rdata = rd;
            #1;
            if (stall) o_stall++;
            if (mem_en) begin
                o_en++;
                o_addr = mem_addr;
                o_wd   = mem_wdata;
                o_size = mem_size;
            end
            if (err) o_err++;
            if (rdata_valid) begin
                o_vld++;
                o_rdata = rdata_out;
            end
            @(negedge CLK);
            req_en = 1'b0;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; req_en = 1'b1; req_rw = 1'b0; req_size = 2'b10;
        req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF; mem_ready = 1'b0; mem_rdata = 32'h0;

        // Reset state, with a request pending to show stall is masked.
        @(negedge CLK); @(negedge CLK); #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_err", 32'(err), 0);
        check("rst_vld", 32'(rdata_valid), 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_addr", mem_addr, 0);
        @(negedge CLK);
        req_en = 1'b0; CLR = 1'b0;
        @(negedge CLK);

        // Word read, ready on third BUSY cycle.
        access(1'b0, 2'b10, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        check("w_rd_stall", o_stall, 4);
        check("w_rd_en", o_en, 3);
        check("w_rd_addr", o_addr, 32'h100);
        check("w_rd_size", 32'(o_size), 2);
        check("w_rd_data", o_rdata, 32'hDEADBEEF);
        check("w_rd_vld", o_vld, 1);
        check("w_rd_err", o_err, 0);

        // Byte reads from the top and a middle lane, minimum latency.
        access(1'b0, 2'b00, 32'h103, 32'h0, 1, 32'hAABBCCDD);
        check("b3_stall", o_stall, 2);
        check("b3_addr", o_addr, 32'h103);
        check("b3_data", o_rdata, 32'h000000AA);
        access(1'b0, 2'b00, 32'h101, 32'h0, 1, 32'hAABBCCDD);
        check("b1_data", o_rdata, 32'h000000CC);

        // Halfword read from upper lane.
        access(1'b0, 2'b01, 32'h102, 32'h0, 2, 32'h11223344);
        check("h2_data", o_rdata, 32'h00001122);
        check("h2_size", 32'(o_size), 1);

        // Halfword write that never completes: timeout after 16 BUSY cycles.
        access(1'b1, 2'b01, 32'h202, 32'h1234, -1, 32'h0);
        check("to_stall", o_stall, 17);
        check("to_en", o_en, 16);
        check("to_err", o_err, 1);
        check("to_vld", o_vld, 0);
        check("to_wdata", o_wd, 32'h12341234);
        check("to_addr", o_addr, 32'h202);
        check("to_rdata_zero", rdata_out, 32'h0);
        check("to_mem_en_after", 32'(mem_en), 0);

        // Ready on the final allowed cycle counts as success.
        access(1'b0, 2'b10, 32'h300, 32'h0, 16, 32'h55AA55AA);
        check("edge_err", o_err, 0);
        check("edge_en", o_en, 16);
        check("edge_data", o_rdata, 32'h55AA55AA);

        // Ready one cycle too late (arrives in DONE) is ignored; timeout stands.
        access(1'b0, 2'b10, 32'h304, 32'h0, 17, 32'h12345678);
        check("late_err", o_err, 1);
        check("late_data", o_rdata, 32'h0);

        // Byte write replication.
        access(1'b1, 2'b00, 32'h301, 32'h5A, 1, 32'h0);
        check("bw_wdata", o_wd, 32'h5A5A5A5A);
        check("bw_err", o_err, 0);
        check("bw_vld", o_vld, 0);

        // Misaligned word read.
        access(1'b0, 2'b10, 32'h101, 32'h0, 1, 32'h01020304);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_w_en", o_en, 0);
        check("mis_w_err", o_err, 1);
        check("mis_w_stall", o_stall, 1);
`else
        check("mis_w_addr", o_addr, 32'h100);
        check("mis_w_err", o_err, 0);
        check("mis_w_data", o_rdata, 32'h01020304);
`endif

        // Illegal size, then misaligned halfword.
        access(1'b0, 2'b11, 32'h203, 32'h0, 1, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
        check("ill_en", o_en, 0);
        check("ill_err", o_err, 1);
`else
        check("ill_size", 32'(o_size), 2);
        check("ill_addr", o_addr, 32'h200);
        check("ill_data", o_rdata, 32'hCAFEF00D);
`endif
        access(1'b0, 2'b01, 32'h103, 32'h0, 1, 32'h87654321);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_h_err", o_err, 1);
`else
        check("mis_h_addr", o_addr, 32'h102);
        check("mis_h_data", o_rdata, 32'h00008765);
`endif

        // mem_ready while IDLE does nothing.
        mem_ready = 1'b1; #1;
        check("idle_rdy_stall", 32'(stall), 0);
        @(negedge CLK); mem_ready = 1'b0; #1;
        check("idle_rdy_vld", 32'(rdata_valid), 0);
        check("idle_rdy_en", 32'(mem_en), 0);

        // Reset in the middle of BUSY.
        @(negedge CLK);
        req_en = 1'b1; req_rw = 1'b0; req_size = 2'b10; req_addr = 32'h400;
        @(negedge CLK); req_en = 1'b0;
        @(negedge CLK); #1;
        check("clr_pre_en", 32'(mem_en), 1);
        CLR = 1'b1; #1;
        check("clr_en", 32'(mem_en), 0);
        check("clr_stall", 32'(stall), 0);
        check("clr_err", 32'(err), 0);
        check("clr_addr", mem_addr, 0);
        @(negedge CLK); CLR = 1'b0; mem_ready = 1'b1; #1;
        check("clr_idle_stall", 32'(stall), 0);
        @(negedge CLK); mem_ready = 1'b0; #1;
        check("clr_no_resume_en", 32'(mem_en), 0);
        check("clr_no_err", 32'(err), 0);
        check("clr_no_vld", 32'(rdata_valid), 0);

        // Back-to-back with req_en held through DONE.
        @(negedge CLK);
        req_en = 1'b1; req_rw = 1'b0; req_size = 2'b10; req_addr = 32'h500; #1;
        check("b2b_idle_stall", 32'(stall), 1);
        @(negedge CLK); mem_ready = 1'b1; mem_rdata = 32'h0BADF00D; #1;
        check("b2b_busy_addr", mem_addr, 32'h500);
        @(negedge CLK); mem_ready = 1'b0; req_addr = 32'h504; #1;
        check("b2b_done_stall", 32'(stall), 0);
        check("b2b_done_en", 32'(mem_en), 0);
        check("b2b_done_vld", 32'(rdata_valid), 1);
        check("b2b_done_data", rdata_out, 32'h0BADF00D);
        @(negedge CLK); #1;
        check("b2b_idle2_stall", 32'(stall), 1);
        check("b2b_idle2_en", 32'(mem_en), 0);
        @(negedge CLK); req_en = 1'b0; mem_ready = 1'b1; #1;
        check("b2b_busy2_en", 32'(mem_en), 1);
        check("b2b_busy2_addr", mem_addr, 32'h504);
        @(negedge CLK); mem_ready = 1'b0; #1;
        check("b2b_done2_vld", 32'(rdata_valid), 1);
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
